uart_rx_ext: RTL

UART_RX_EXT -- requirements
Module: uart_rx_ext

---
 rtl/uart_rx_ext_if.sv | 14 +
 rtl/uart_rx_ext.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext_if.sv
// Consumer-side handshake of uart_rx_ext: received word, valid/ready pair and the
// per-word error flags that travel with it.
interface uart_rx_ext_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;

    modport master (output rx_data, rx_valid, parity_err, frame_err, input rx_ready);
    modport slave  (input rx_data, rx_valid, parity_err, frame_err, output rx_ready);
endinterface

// File: rtl/uart_rx_ext.sv
// UART receiver with 3-flop input synchronizer, 2-of-3 mid-bit voting, optional parity,
// one or two stop bits, break detection and a valid/ready output holding register.
module uart_rx_ext #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int UART_BPS  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          uart_rxdata,
    uart_rx_ext_if.master rx_if,
    output logic          overrun_err,
    output logic          break_det,
    output logic          busy
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int HALF         = BAUD_CNT_MAX / 2;
    localparam int CW           = $clog2(BAUD_CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_WRAP = CW'(BAUD_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        majority3 = (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_expect(input logic [DATA_BITS-1:0] data);
        if (PARITY == 2) parity_expect = ^data;
        else             parity_expect = ~^data;
    endfunction

    logic                 s0_r, s1_r, s2_r;
    state_t               state_r, state_s;
    logic [CW-1:0]        cnt_r;
    logic [1:0]           maj_r;
    logic [3:0]           bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bit_r, perr_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r, parity_err_r, frame_err_r;
    logic                 overrun_r, break_r, busy_r;
    logic                 start_edge_s, dec_s, wrap_s, bit_s, frame_zero_s;
    logic                 done_s, ferr_s, brk_s;

    assign start_edge_s = s2_r & ~s1_r;
    assign dec_s        = (cnt_r == CNT_DEC);
    assign wrap_s       = (cnt_r == CNT_WRAP);
    assign bit_s        = majority3(maj_r[0], maj_r[1], s2_r);
    assign frame_zero_s = (shift_r == {DATA_BITS{1'b0}}) && ((PARITY == 0) || !par_bit_r);

    assign rx_if.rx_data    = rx_data_r;
    assign rx_if.rx_valid   = rx_valid_r;
    assign rx_if.parity_err = parity_err_r;
    assign rx_if.frame_err  = frame_err_r;
    assign overrun_err      = overrun_r;
    assign break_det        = break_r;
    assign busy             = busy_r;

    // Frame sequencing; completion is flagged at the last stop-bit decision point.
    always_comb begin
        state_s = state_r;
        done_s  = 1'b0;
        ferr_s  = 1'b0;
        brk_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) state_s = ST_START;
                else              state_s = ST_IDLE;
            end
            ST_START: begin
                if (dec_s && bit_s) state_s = ST_IDLE;
                else if (wrap_s)    state_s = ST_DATA;
                else                state_s = ST_START;
            end
            ST_DATA: begin
                if (wrap_s && (bit_cnt_r == DATA_LAST)) state_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
                else                                    state_s = ST_DATA;
            end
            ST_PARITY: begin
                if (wrap_s) state_s = ST_STOP;
                else        state_s = ST_PARITY;
            end
            ST_STOP: begin
                if (dec_s && !bit_s) begin
                    ferr_s  = 1'b1;
                    brk_s   = frame_zero_s;
                    done_s  = !frame_zero_s;
                    state_s = ST_WAIT_IDLE;
                end else if (dec_s && (bit_cnt_r == STOP_LAST)) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_WAIT_IDLE: begin
                if (s2_r) state_s = ST_IDLE;
                else      state_s = ST_WAIT_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Synchronizer, state, baud counter and receive datapath.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_r      <= 1'b1;
            s1_r      <= 1'b1;
            s2_r      <= 1'b1;
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            maj_r     <= 2'b00;
            bit_cnt_r <= 4'd0;
            shift_r   <= '0;
            par_bit_r <= 1'b0;
            perr_r    <= 1'b0;
        end else begin
            s0_r    <= uart_rxdata;
            s1_r    <= s0_r;
            s2_r    <= s1_r;
            state_r <= state_s;
            if ((state_s == ST_IDLE) || ((state_s == ST_START) && (state_r != ST_START)) || wrap_s)
                cnt_r <= '0;
            else
                cnt_r <= cnt_r + 1'b1;
            if (cnt_r == CNT_S0) maj_r[0] <= s2_r;
            if (cnt_r == CNT_S1) maj_r[1] <= s2_r;
            if (state_s != state_r)
                bit_cnt_r <= 4'd0;
            else if (dec_s && ((state_r == ST_DATA) || (state_r == ST_STOP)))
                bit_cnt_r <= bit_cnt_r + 4'd1;
            if ((state_r == ST_DATA) && dec_s)
                shift_r <= {bit_s, shift_r[DATA_BITS-1:1]};
            if (state_r == ST_IDLE) begin
                par_bit_r <= 1'b0;
                perr_r    <= 1'b0;
            end else if ((state_r == ST_PARITY) && dec_s) begin
                par_bit_r <= bit_s;
                perr_r    <= (bit_s != parity_expect(shift_r));
            end
        end
    end

    // Output holding register with overrun, break and busy reporting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            break_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            if (done_s && (!rx_valid_r || rx_if.rx_ready)) begin
                rx_data_r    <= shift_r;
                parity_err_r <= perr_r;
                frame_err_r  <= ferr_s;
                rx_valid_r   <= 1'b1;
            end else if (rx_valid_r && rx_if.rx_ready) begin
                rx_valid_r <= 1'b0;
            end
            overrun_r <= done_s && rx_valid_r && !rx_if.rx_ready;
            break_r   <= brk_s;
            busy_r    <= (state_s != ST_IDLE);
        end
    end
endmodule
